// File: rtl/i2c_slave_buffered_if.sv
// Pin and host-port bundle for i2c_slave_buffered: open-drain I2C lines, host buffer port
// and status outputs.
interface i2c_slave_buffered_if #(
  parameter int unsigned PTR_W = 3
);
  logic             scl_in;
  logic             scl_out;
  logic             sda_in;
  logic             sda_out;
  logic [PTR_W-1:0] host_addr;
  logic [7:0]       host_wdata;
  logic             host_we;
  logic [7:0]       host_rdata;
  logic             host_hold;
  logic             i2c_wr;
  logic             i2c_rd;
  logic [PTR_W-1:0] i2c_ptr;
  logic             collision;
  logic             read_write_flag;
  logic             bus_status;
  logic             transfer_status;
  logic             stretching;

  modport slave (
    input  scl_in, sda_in, host_addr, host_wdata, host_we, host_hold,
    output scl_out, sda_out, host_rdata, i2c_wr, i2c_rd, i2c_ptr, collision,
           read_write_flag, bus_status, transfer_status, stretching
  );

  modport master (
    output scl_in, sda_in, host_addr, host_wdata, host_we, host_hold,
    input  scl_out, sda_out, host_rdata, i2c_wr, i2c_rd, i2c_ptr, collision,
           read_write_flag, bus_status, transfer_status, stretching
  );
endinterface

// File: rtl/i2c_slave_buffered.sv
// Buffered I2C slave: register-pointer addressing, auto-increment bursts, optional SCL
// stretching, and a synchronous host port onto the same byte buffer.
module i2c_slave_buffered #(
  parameter int unsigned BUF_DEPTH  = 8,
  parameter int unsigned PTR_W      = 3,
  parameter bit          STRETCH_EN = 1'b1
) (
  input logic                 clock,
  input logic                 reset_n,
  input logic                 enable,
  input logic [6:0]           address,
  i2c_slave_buffered_if.slave bus
);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck, StWdata, StWdataAck,
    StRdata, StRdataChk, StHold, StWait
  } state_e;

  state_e           state_q, state_d, pend_q, pend_d, ack_tgt;
  logic [PTR_W-1:0] ptr_q, ptr_d, i2c_ptr_q, i2c_ptr_d;
  logic [7:0]       shreg_q, shreg_d, host_rdata_q;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic             sda_out_q, sda_out_d, scl_out_q, scl_out_d, stretching_q, stretching_d;
  logic             rw_q, rw_d, bus_q, bus_d, xfer_q, xfer_d;
  logic             i2c_wr_q, i2c_wr_d, i2c_rd_q, i2c_rd_d, coll_q;
  logic             scl_q, scl_p, sda_q, sda_p;
  logic             scl_rise, scl_fall, start_det, stop_det, ack_end, load, wr_en;
  logic [7:0]       mem_q [BUF_DEPTH];

  assign scl_rise  = scl_q & ~scl_p;
  assign scl_fall  = ~scl_q & scl_p;
  assign start_det = scl_q & scl_p & sda_p & ~sda_q;
  assign stop_det  = scl_q & scl_p & ~sda_p & sda_q;

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    ptr_d        = ptr_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    sda_out_d    = sda_out_q;
    scl_out_d    = scl_out_q;
    stretching_d = stretching_q;
    rw_d         = rw_q;
    bus_d        = bus_q;
    xfer_d       = xfer_q;
    i2c_wr_d     = 1'b0;
    i2c_rd_d     = 1'b0;
    i2c_ptr_d    = i2c_ptr_q;
    ack_end      = 1'b0;
    ack_tgt      = StIdle;
    load         = 1'b0;
    wr_en        = 1'b0;

    if (stop_det) begin
      state_d      = StIdle;
      sda_out_d    = 1'b1;
      scl_out_d    = 1'b1;
      stretching_d = 1'b0;
      bus_d        = 1'b0;
      xfer_d       = 1'b0;
    end else if (start_det) begin
      bus_d  = 1'b1;
      xfer_d = 1'b0;
      if (state_q != StIdle || enable) begin
        state_d      = StAddr;
        bit_cnt_d    = '0;
        sda_out_d    = 1'b1;
        scl_out_d    = 1'b1;
        stretching_d = 1'b0;
      end
    end else begin
      case (state_q)
        StAddr, StPtr, StWdata: begin
          if (scl_rise) begin
            shreg_d   = {shreg_q[6:0], sda_q};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == StAddr) begin
                if (shreg_d[7:1] == address) begin
                  state_d = StAddrAck;
                  rw_d    = shreg_d[0];
                  xfer_d  = 1'b1;
                end else begin
                  state_d = StWait;
                end
              end else if (state_q == StPtr) begin
                ptr_d   = shreg_d[PTR_W-1:0];
                state_d = StPtrAck;
              end else begin
                wr_en     = 1'b1;
                i2c_wr_d  = 1'b1;
                i2c_ptr_d = ptr_q;
                ptr_d     = ptr_q + PTR_W'(1);
                state_d   = StWdataAck;
              end
            end
          end
        end
        StAddrAck, StPtrAck, StWdataAck: begin
          // First fall after the 8th bit starts driving ACK; the second one ends it.
          if (scl_fall) begin
            if (sda_out_q) begin
              sda_out_d = 1'b0;
            end else begin
              ack_end = 1'b1;
              ack_tgt = (state_q == StAddrAck) ? (rw_q ? StRdata : StPtr) : StWdata;
            end
          end
        end
        StRdata: begin
          if (scl_fall) begin
            if (bit_cnt_q == 3'd7) begin
              sda_out_d = 1'b1;
              state_d   = StRdataChk;
            end else begin
              shreg_d   = {shreg_q[6:0], 1'b0};
              sda_out_d = shreg_q[6];
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        StRdataChk: begin
          if (scl_rise && sda_q) begin
            state_d = StWait;
          end else if (scl_fall) begin
            ptr_d   = ptr_q + PTR_W'(1);
            ack_end = 1'b1;
            ack_tgt = StRdata;
          end
        end
        StHold: begin
          if (!bus.host_hold) begin
            state_d      = pend_q;
            scl_out_d    = 1'b1;
            stretching_d = 1'b0;
            load         = (pend_q == StRdata);
          end
        end
        StIdle, StWait: ;
        default: state_d = StIdle;
      endcase

      if (ack_end) begin
        sda_out_d = 1'b1;
        bit_cnt_d = '0;
        if (STRETCH_EN && bus.host_hold) begin
          state_d      = StHold;
          pend_d       = ack_tgt;
          scl_out_d    = 1'b0;
          stretching_d = 1'b1;
        end else begin
          state_d = ack_tgt;
          load    = (ack_tgt == StRdata);
        end
      end

      if (load) begin
        shreg_d   = mem_q[ptr_d];
        sda_out_d = mem_q[ptr_d][7];
        bit_cnt_d = '0;
        i2c_rd_d  = 1'b1;
        i2c_ptr_d = ptr_d;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      pend_q       <= StIdle;
      ptr_q        <= '0;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      sda_out_q    <= 1'b1;
      scl_out_q    <= 1'b1;
      stretching_q <= 1'b0;
      rw_q         <= 1'b0;
      bus_q        <= 1'b0;
      xfer_q       <= 1'b0;
      i2c_wr_q     <= 1'b0;
      i2c_rd_q     <= 1'b0;
      i2c_ptr_q    <= '0;
      coll_q       <= 1'b0;
      host_rdata_q <= '0;
      scl_q        <= 1'b1;
      scl_p        <= 1'b1;
      sda_q        <= 1'b1;
      sda_p        <= 1'b1;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      ptr_q        <= ptr_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      sda_out_q    <= sda_out_d;
      scl_out_q    <= scl_out_d;
      stretching_q <= stretching_d;
      rw_q         <= rw_d;
      bus_q        <= bus_d;
      xfer_q       <= xfer_d;
      i2c_wr_q     <= i2c_wr_d;
      i2c_rd_q     <= i2c_rd_d;
      i2c_ptr_q    <= i2c_ptr_d;
      coll_q       <= wr_en && bus.host_we && (bus.host_addr == ptr_q);
      scl_q        <= bus.scl_in;
      scl_p        <= scl_q;
      sda_q        <= bus.sda_in;
      sda_p        <= sda_q;
      // Write-first view; the I2C byte wins a same-index collision.
      if (wr_en && (bus.host_addr == ptr_q)) host_rdata_q <= shreg_d;
      else if (bus.host_we)                  host_rdata_q <= bus.host_wdata;
      else                                   host_rdata_q <= mem_q[bus.host_addr];
    end
  end

  // Buffer contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (bus.host_we && !(wr_en && (bus.host_addr == ptr_q))) begin
      mem_q[bus.host_addr] <= bus.host_wdata;
    end
    if (wr_en) mem_q[ptr_q] <= shreg_d;
  end

  assign bus.sda_out         = sda_out_q;
  assign bus.scl_out         = STRETCH_EN ? scl_out_q : 1'b1;
  assign bus.stretching      = stretching_q;
  assign bus.host_rdata      = host_rdata_q;
  assign bus.i2c_wr          = i2c_wr_q;
  assign bus.i2c_rd          = i2c_rd_q;
  assign bus.i2c_ptr         = i2c_ptr_q;
  assign bus.collision       = coll_q;
  assign bus.read_write_flag = rw_q;
  assign bus.bus_status      = bus_q;
  assign bus.transfer_status = xfer_q;

endmodule
